irrigation_zone_sequencer: RTL and testbench
============================================

# irrigation_zone_sequencer

- Parametrised multi-zone successor to the single-channel irrigation timer.
- Alternates a wait period with a watering period, but now serves N_ZONES valves from one pump.
- Picks the next dry zone round-robin, sequences valve-before-pump and pump-before-valve, and drives the red/blue status LEDs.
- Sits between the soil-moisture sensor inputs and the pump/valve driver outputs.

## Interface
- N_ZONES, 4, number of valve channels (1..16)
- WAIT_CYC, 250000000, clk cycles spent in WAIT (5 s at 50 MHz)
- WATER_CYC, 300000000, clk cycles of pump-on watering per zone (6 s at 50 MHz)
- LEAD_CYC, 50000000, clk cycles the valve is open with the pump off, before and after watering
- CNT_W, 32, duration counter width; every *_CYC value must fit in CNT_W bits
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous and active-high
- enable  in  1  run permission; low forces the idle/wait behaviour
- dry  in  N_ZONES  per-zone soil sensor, 1 = dry; asynchronous
- pump_on  out  1  pump drive
- valve  out  N_ZONES  valve drive; at most one bit high (one-hot or zero)
- zone  out  $clog2(N_ZONES) (min 1)  index of the zone currently/last served
- redLED  out  1  high when the pump is off
- blueLED  out  1  high when the pump is on; always equals ~redLED
- cycle_done  out  1  one-cycle pulse when a zone completes CLOSE

## Operation
- dry passes through a 2-flop synchronizer; dry_s below means the synchronized value.
- FSM states are WAIT, OPEN, WATER and CLOSE. A single counter cnt is cleared on every state entry.
- WAIT
  - valve=0, pump_on=0.
  - When cnt==WAIT_CYC-1, scan zones round-robin starting at last+1 (mod N_ZONES), where last is the most recently served zone.
  - If a zone with dry_s=1 is found: zone<=that index, go to OPEN.
  - If no zone is dry: stay in WAIT and restart cnt.
  - If enable=0: hold cnt at 0.
- OPEN: valve[zone]=1, pump_on=0. When cnt==LEAD_CYC-1, go to WATER.
- WATER: valve[zone]=1, pump_on=1. When cnt==WATER_CYC-1, go to CLOSE.
- CLOSE
  - valve[zone]=1, pump_on=0.
  - When cnt==LEAD_CYC-1: last<=zone, pulse cycle_done, go to WAIT.
- enable=0 in OPEN or WATER: go to CLOSE on the next edge, so the pump is off and the valve drains for the full lead time. CLOSE itself is never aborted.
- The pump is never on while every valve is closed. valve switches only on WAIT<->OPEN/CLOSE edges.
- N_ZONES=1: the scan degenerates to zone 0 every time.
- WAIT_CYC, WATER_CYC and LEAD_CYC must each be >=1. A value of 1 gives a single-cycle state.

## Timing
- Reset values
  - State WAIT, cnt=0, last=N_ZONES-1, so the first scan starts at zone 0.
  - zone=0, valve=0, pump_on=0, redLED=1, blueLED=0, cycle_done=0.
  - Synchronizer flops are cleared to 0.
- All outputs are registered and change on the clk edge that enters the new state.
- Each state lasts exactly its *_CYC count in cycles.
- A full zone service takes WAIT_CYC + 2*LEAD_CYC + WATER_CYC cycles.
- dry-to-decision latency is 2 cycles: a sensor change is visible to the scan 2 edges later.
- rst mid-operation: the next edge returns to the reset values immediately. The pump and valve drop in the same cycle; no CLOSE is performed.
- cycle_done is high for exactly the first cycle of WAIT after a CLOSE.

## Configuration
- IRR_WET_CUTOFF_EN
- Defined:
  - In WATER, dry_s[zone]==0 (soil became wet) ends watering early: go to CLOSE on the next edge.
  - The rest of CLOSE and the cycle_done pulse are unchanged.
- Undefined: WATER always runs the full WATER_CYC, regardless of dry.

## Test plan
All scenarios use N_ZONES=4, WAIT_CYC=10, WATER_CYC=20, LEAD_CYC=3.

- rst high 2 cycles, dry=4'b0000, run 50 cycles -> outputs stay at reset values. No OPEN is entered; redLED=1, valve=0.
- dry=4'b1010 held -> zone 1 is served first.
  - valve=4'b0010 rises 10 cycles after rst release.
  - pump_on is high for exactly 20 cycles, starting 3 cycles after the valve opens.
  - cycle_done pulses, then zone 3 is served next, then zone 1 again.
- enable dropped 5 cycles into WATER -> pump_on falls on the next edge. The valve stays open 3 more cycles, then closes; cycle_done pulses.
- rst asserted during WATER -> pump_on=0 and valve=0 after one edge. After release, the scan starts again at zone 0.
- With IRR_WET_CUTOFF_EN: dry[2] falls 4 cycles into WATER -> pump_on falls 2-3 cycles later (synchronizer latency). Without the macro, the same stimulus gives a full 20-cycle pump pulse.
- Check on every cycle: blueLED==~redLED, valve is one-hot or zero, and pump_on is never high while valve==0.

Source files
------------

// File: rtl/irrigation_zone_sequencer.sv
// irrigation_zone_sequencer
// Multi-zone irrigation sequencer: one pump serving N_ZONES valves.
// Cycle: WAIT -> OPEN (valve only) -> WATER (valve + pump) -> CLOSE (valve only).
// The next dry zone is chosen round-robin, starting after the last served zone.
// Optional build macro IRR_WET_CUTOFF_EN: when defined, wet soil on the active
// zone ends WATER early. When undefined, WATER always runs its full length.

module irrigation_zone_sequencer #(
   parameter int unsigned N_ZONES   = 4,
   parameter int unsigned WAIT_CYC  = 250_000_000,
   parameter int unsigned WATER_CYC = 300_000_000,
   parameter int unsigned LEAD_CYC  = 50_000_000,
   parameter int unsigned CNT_W     = 32,
   localparam int unsigned ZONE_W   = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [N_ZONES-1:0] dry,
   output logic               pump_on,
   output logic [N_ZONES-1:0] valve,
   output logic [ZONE_W-1:0]  zone,
   output logic               redLED,
   output logic               blueLED,
   output logic               cycle_done
);

   typedef enum logic [1:0] {
      S_WAIT,
      S_OPEN,
      S_WATER,
      S_CLOSE
   } state_e;

   // Terminal counts: each state ends on the cycle its counter reaches *_CYC-1.
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] WATER_LAST = CNT_W'(WATER_CYC - 1);
   localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(LEAD_CYC - 1);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ZONE_W-1:0]   zone_q;
   logic [ZONE_W-1:0]   last_q;
   logic [N_ZONES-1:0]  valve_q;
   logic                pump_on_q;
   logic                cycle_done_q;
   logic [N_ZONES-1:0]  dry_meta_q;
   logic [N_ZONES-1:0]  dry_s_q;

   logic                scan_found;
   logic [ZONE_W-1:0]   scan_idx;
   logic [ZONE_W-1:0]   scan_cand;
   logic [N_ZONES-1:0]  scan_onehot;
   logic                wet_stop;

   // Two-flop synchronizer for the asynchronous soil sensors.
   // NOTE: every clocked block uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         dry_meta_q <= '0;
         dry_s_q    <= '0;
      end else begin
         dry_meta_q <= dry;
         dry_s_q    <= dry_meta_q;
      end
   end

   // Round-robin scan: first dry zone found starting at last_q+1, wrapping modulo N_ZONES.
   always_comb begin
      // NOTE: defaults before the loop keep every path assigned, so no latches are inferred.
      scan_found  = 1'b0;
      scan_idx    = '0;
      scan_cand   = '0;
      scan_onehot = '0;
      for (int unsigned k = 1; k <= N_ZONES; k++) begin
         scan_cand = ZONE_W'((32'(last_q) + k) % N_ZONES);
         if (!scan_found && dry_s_q[scan_cand]) begin
            scan_found = 1'b1;
            scan_idx   = scan_cand;
         end
      end
      if (scan_found) begin
         scan_onehot[scan_idx] = 1'b1;
      end
   end

`ifdef IRR_WET_CUTOFF_EN
   assign wet_stop = ~dry_s_q[zone_q];
`else
   assign wet_stop = 1'b0;
`endif

   // Sequencer FSM: state, duration counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_WAIT;
         cnt_q        <= '0;
         zone_q       <= '0;
         last_q       <= ZONE_W'(N_ZONES - 1);
         valve_q      <= '0;
         pump_on_q    <= 1'b0;
         cycle_done_q <= 1'b0;
      end else begin
         cycle_done_q <= 1'b0;
         cnt_q        <= cnt_q + 1'b1;
         case (state_q)
            S_WAIT: begin
               if (!enable) begin
                  cnt_q <= '0;
               end else if (cnt_q == WAIT_LAST) begin
                  cnt_q <= '0;
                  if (scan_found) begin
                     state_q <= S_OPEN;
                     zone_q  <= scan_idx;
                     valve_q <= scan_onehot;
                  end
               end
            end
            S_OPEN: begin
               if (!enable) begin
                  state_q <= S_CLOSE;
                  cnt_q   <= '0;
               end else if (cnt_q == LEAD_LAST) begin
                  state_q   <= S_WATER;
                  cnt_q     <= '0;
                  pump_on_q <= 1'b1;
               end
            end
            S_WATER: begin
               if (!enable || wet_stop || cnt_q == WATER_LAST) begin
                  state_q   <= S_CLOSE;
                  cnt_q     <= '0;
                  pump_on_q <= 1'b0;
               end
            end
            S_CLOSE: begin
               // Draining is never aborted; only the lead time ends it.
               if (cnt_q == LEAD_LAST) begin
                  state_q      <= S_WAIT;
                  cnt_q        <= '0;
                  valve_q      <= '0;
                  last_q       <= zone_q;
                  cycle_done_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= S_WAIT;
               cnt_q     <= '0;
               valve_q   <= '0;
               pump_on_q <= 1'b0;
            end
         endcase
      end
   end

   assign pump_on    = pump_on_q;
   assign valve      = valve_q;
   assign zone       = zone_q;
   assign redLED     = ~pump_on_q;
   assign blueLED    = pump_on_q;
   assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// Testbench for irrigation_zone_sequencer (N_ZONES=4, WAIT=10, WATER=20, LEAD=3).
// A count-down phase model predicts every output each cycle; scenario tasks add
// targeted timing checks. Honours IRR_WET_CUTOFF_EN when defined at compile time.

module tb_irrigation_zone_sequencer;

   localparam int N         = 4;
   localparam int WAIT_CYC  = 10;
   localparam int WATER_CYC = 20;
   localparam int LEAD_CYC  = 3;

   localparam int P_WAIT  = 0;
   localparam int P_OPEN  = 1;
   localparam int P_WATER = 2;
   localparam int P_CLOSE = 3;

`ifdef IRR_WET_CUTOFF_EN
   localparam bit CUTOFF = 1'b1;
`else
   localparam bit CUTOFF = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic [3:0] dry = 4'b0000;

   logic       pump_on;
   logic [3:0] valve;
   logic [1:0] zone;
   logic       redLED;
   logic       blueLED;
   logic       cycle_done;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   irrigation_zone_sequencer #(
      .N_ZONES  (N),
      .WAIT_CYC (WAIT_CYC),
      .WATER_CYC(WATER_CYC),
      .LEAD_CYC (LEAD_CYC),
      .CNT_W    (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .dry       (dry),
      .pump_on   (pump_on),
      .valve     (valve),
      .zone      (zone),
      .redLED    (redLED),
      .blueLED   (blueLED),
      .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: phase + cycles remaining ----------------
   int         m_phase;
   int         m_left;
   int         m_zone;
   int         m_last;
   logic       m_done;
   logic [3:0] m_s1;
   logic [3:0] m_ds;
   bit         m_found;
   int         m_z;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = P_WAIT;
         m_left  = WAIT_CYC;
         m_zone  = 0;
         m_last  = N - 1;
         m_done  = 1'b0;
         m_s1    = 4'b0000;
         m_ds    = 4'b0000;
      end else begin
         m_done = 1'b0;
         case (m_phase)
            P_WAIT: begin
               if (!enable) begin
                  m_left = WAIT_CYC;
               end else if (m_left == 1) begin
                  m_found = 1'b0;
                  for (int k = 1; k <= N; k++) begin
                     m_z = (m_last + k) % N;
                     if (!m_found && m_ds[m_z]) begin
                        m_found = 1'b1;
                        m_zone  = m_z;
                     end
                  end
                  if (m_found) begin
                     m_phase = P_OPEN;
                     m_left  = LEAD_CYC;
                  end else begin
                     m_left = WAIT_CYC;
                  end
               end else begin
                  m_left--;
               end
            end
            P_OPEN: begin
               if (!enable) begin
                  m_phase = P_CLOSE;
                  m_left  = LEAD_CYC;
               end else if (m_left == 1) begin
                  m_phase = P_WATER;
                  m_left  = WATER_CYC;
               end else begin
                  m_left--;
               end
            end
            P_WATER: begin
               if (!enable || m_left == 1 || (CUTOFF && !m_ds[m_zone])) begin
                  m_phase = P_CLOSE;
                  m_left  = LEAD_CYC;
               end else begin
                  m_left--;
               end
            end
            default: begin
               if (m_left == 1) begin
                  m_phase = P_WAIT;
                  m_left  = WAIT_CYC;
                  m_last  = m_zone;
                  m_done  = 1'b1;
               end else begin
                  m_left--;
               end
            end
         endcase
         m_ds = m_s1;
         m_s1 = dry;
      end
   end

   // ---------------- per-cycle monitor: model comparison and invariants ----------------
   logic       exp_pump;
   logic [3:0] exp_valve;

   always @(negedge clk) begin
      if (mon_en) begin
         exp_pump  = (m_phase == P_WATER);
         exp_valve = (m_phase != P_WAIT) ? (4'b0001 << m_zone) : 4'b0000;
         checks++;
         if (pump_on !== exp_pump) begin
            errors++;
            $display("FAIL mon_pump t=%0t got=%b exp=%b", $time, pump_on, exp_pump);
         end
         checks++;
         if (valve !== exp_valve) begin
            errors++;
            $display("FAIL mon_valve t=%0t got=%b exp=%b", $time, valve, exp_valve);
         end
         checks++;
         if (zone !== 2'(m_zone)) begin
            errors++;
            $display("FAIL mon_zone t=%0t got=%0d exp=%0d", $time, zone, m_zone);
         end
         checks++;
         if (cycle_done !== m_done) begin
            errors++;
            $display("FAIL mon_done t=%0t got=%b exp=%b", $time, cycle_done, m_done);
         end
         checks++;
         if (redLED !== ~exp_pump) begin
            errors++;
            $display("FAIL mon_red t=%0t got=%b exp=%b", $time, redLED, ~exp_pump);
         end
         checks++;
         if (blueLED !== ~redLED) begin
            errors++;
            $display("FAIL inv_led t=%0t blue=%b red=%b", $time, blueLED, redLED);
         end
         checks++;
         if (!$onehot0(valve) || (pump_on === 1'b1 && valve === 4'b0000)) begin
            errors++;
            $display("FAIL inv_valve t=%0t valve=%b pump=%b", $time, valve, pump_on);
         end
      end
   end

   // ---------------- stimulus helpers (no comparisons) ----------------
   task automatic do_reset(input logic [3:0] d);
      @(negedge clk);
      rst    = 1'b1;
      dry    = d;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // sel: 0 valve open, 1 pump on, 2 pump off, 3 cycle_done. n=-1 on timeout.
   task automatic wait_for(input int sel, output int n);
      bit hit;
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = (valve !== 4'b0000);
            1:       hit = (pump_on === 1'b1);
            2:       hit = (pump_on === 1'b0);
            default: hit = (cycle_done === 1'b1);
         endcase
         if (hit) begin
            n = i;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      dry = 4'b0000;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if ({pump_on, valve, zone, redLED, blueLED, cycle_done} !== 10'b0_0000_00_1_0_0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i,
                     {pump_on, valve, zone, redLED, blueLED, cycle_done}, 10'b0_0000_00_1_0_0);
         end
      end
   endtask

   task automatic test_zone_order();
      int n;
      do_reset(4'b1010);
      wait_for(0, n);
      checks++;
      if (n != WAIT_CYC || valve !== 4'b0010 || zone !== 2'd1) begin
         errors++;
         $display("FAIL first_open n=%0d valve=%b zone=%0d exp n=10 valve=0010 zone=1", n, valve, zone);
      end
      wait_for(1, n);
      checks++;
      if (n != LEAD_CYC) begin
         errors++;
         $display("FAIL pump_lead got=%0d exp=%0d", n, LEAD_CYC);
      end
      wait_for(2, n);
      checks++;
      if (n != WATER_CYC) begin
         errors++;
         $display("FAIL pump_len got=%0d exp=%0d", n, WATER_CYC);
      end
      wait_for(3, n);
      checks++;
      if (n != LEAD_CYC || valve !== 4'b0000) begin
         errors++;
         $display("FAIL close_len got=%0d valve=%b exp=%0d valve=0000", n, valve, LEAD_CYC);
      end
      wait_for(0, n);
      checks++;
      if (n != WAIT_CYC || valve !== 4'b1000 || zone !== 2'd3) begin
         errors++;
         $display("FAIL second_open n=%0d valve=%b zone=%0d exp n=10 valve=1000 zone=3", n, valve, zone);
      end
      wait_for(3, n);
      wait_for(0, n);
      checks++;
      if (valve !== 4'b0010 || zone !== 2'd1) begin
         errors++;
         $display("FAIL third_open valve=%b zone=%0d exp valve=0010 zone=1", valve, zone);
      end
   endtask

   task automatic test_enable_drop();
      int n;
      do_reset(4'b0100);
      wait_for(1, n);
      repeat (4) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (pump_on !== 1'b0 || valve !== 4'b0100) begin
         errors++;
         $display("FAIL abort_pump pump=%b valve=%b exp pump=0 valve=0100", pump_on, valve);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (valve !== 4'b0100) begin
            errors++;
            $display("FAIL abort_drain cyc=%0d valve=%b exp=0100", i, valve);
         end
      end
      @(negedge clk);
      checks++;
      if (valve !== 4'b0000 || cycle_done !== 1'b1) begin
         errors++;
         $display("FAIL abort_close valve=%b done=%b exp valve=0000 done=1", valve, cycle_done);
      end
      for (int i = 0; i < 30; i++) @(negedge clk);
      checks++;
      if (valve !== 4'b0000) begin
         errors++;
         $display("FAIL disabled_idle valve=%b exp=0000", valve);
      end
      enable = 1'b1;
   endtask

   task automatic test_rst_mid();
      int n;
      do_reset(4'b1111);
      wait_for(1, n);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (pump_on !== 1'b0 || valve !== 4'b0000 || zone !== 2'd0 || redLED !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid pump=%b valve=%b zone=%0d red=%b exp 0 0000 0 1", pump_on, valve, zone, redLED);
      end
      rst = 1'b0;
      wait_for(0, n);
      checks++;
      if (n != WAIT_CYC || valve !== 4'b0001 || zone !== 2'd0) begin
         errors++;
         $display("FAIL rst_rescan n=%0d valve=%b zone=%0d exp n=10 valve=0001 zone=0", n, valve, zone);
      end
   endtask

   task automatic test_wet_cutoff();
      int n;
      int pump_cycles;
      int exp_cycles;
      do_reset(4'b0100);
      wait_for(1, n);
      repeat (4) @(negedge clk);
      dry = 4'b0000;
      wait_for(2, n);
      pump_cycles = (n < 0) ? -1 : 5 + n - 1;
      exp_cycles  = CUTOFF ? 7 : WATER_CYC;
      checks++;
      if (pump_cycles != exp_cycles) begin
         errors++;
         $display("FAIL wet_cutoff pump_cycles=%0d exp=%0d", pump_cycles, exp_cycles);
      end
      wait_for(3, n);
      checks++;
      if (n != LEAD_CYC) begin
         errors++;
         $display("FAIL wet_close got=%0d exp=%0d", n, LEAD_CYC);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) dry = 4'($urandom);
         if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 599) == 0);
      end
      @(negedge clk);
      rst    = 1'b0;
      enable = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      test_reset();
      test_zone_order();
      test_enable_drop();
      test_rst_mid();
      test_wet_cutoff();
      test_random();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
